fetch_unit: RTL and testbench

// Instruction-fetch front end that consumes the next-PC produced by the execute stage.

---
 rtl/fetch_unit.sv | 112 +++++++++++
 tb/tb_fetch_unit.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: holds the architectural PC, fetches one
// instruction at a time from a variable-latency memory, presents it to
// decode/execute and follows the next PC returned on acknowledgement.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_rd,
  output logic [15:0] imem_addr,
  input  logic        imem_done,
  input  logic [15:0] imem_data,
  output logic [15:0] instr,
  output logic [15:0] pc_plus_2,
  output logic        instr_valid,
  input  logic        instr_ack,
  input  logic [15:0] pc_updated,
  input  logic        halt,
  output logic        halted,
  output logic        err
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_VALID,
    ST_HALT
  } state_t;

  localparam logic [15:0] NOP_INSTR = 16'h0800;
  localparam logic [7:0]  WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        err_q, err_d;

  // Next-state logic: request, wait for memory, present, then redirect or stop.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_REQ;
      end
      ST_REQ: begin
        if (imem_done) begin
          instr_d    = imem_data;
          wait_cnt_d = 8'd0;
          state_d    = ST_VALID;
        end else if (wait_cnt_q == WAIT_LAST) begin
          err_d      = 1'b1;
          wait_cnt_d = 8'd0;
          state_d    = ST_HALT;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      ST_VALID: begin
        if (instr_ack) begin
          if (pc_updated[0]) begin
            err_d   = 1'b1;
            state_d = ST_HALT;
          end else if (halt) begin
            pc_d    = pc_updated;
            state_d = ST_HALT;
          end else begin
            pc_d    = pc_updated;
            state_d = ST_REQ;
          end
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset back to the reset PC and a NOP.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      instr_q    <= NOP_INSTR;
      wait_cnt_q <= 8'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

  assign imem_rd     = (state_q == ST_REQ);
  assign instr_valid = (state_q == ST_VALID);
  assign halted      = (state_q == ST_HALT);
  assign imem_addr   = pc_q;
  assign pc_plus_2   = pc_q + 16'd2;
  assign instr       = instr_q;
  assign err         = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a scoreboard queue holds the expected
// instruction and pc_plus_2 for every memory response driven into the DUT.
module tb_fetch_unit;

  localparam int MODE_NEXT     = 0;
  localparam int MODE_HALT     = 1;
  localparam int MODE_MISALIGN = 2;

  logic        clk;
  logic        rst;
  logic        imem_rd;
  logic [15:0] imem_addr;
  logic        imem_done;
  logic [15:0] imem_data;
  logic [15:0] instr;
  logic [15:0] pc_plus_2;
  logic        instr_valid;
  logic        instr_ack;
  logic [15:0] pc_updated;
  logic        halt;
  logic        halted;
  logic        err;

  int          checkCount = 0;
  int          passCount  = 0;
  logic [15:0] expPc;
  logic [31:0] scoreboard[$];

  fetch_unit #(
    .RESET_PC(16'h0000),
    .MAX_WAIT(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_rd    (imem_rd),
    .imem_addr  (imem_addr),
    .imem_done  (imem_done),
    .imem_data  (imem_data),
    .instr      (instr),
    .pc_plus_2  (pc_plus_2),
    .instr_valid(instr_valid),
    .instr_ack  (instr_ack),
    .pc_updated (pc_updated),
    .halt       (halt),
    .halted     (halted),
    .err        (err)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the flow ever stalls.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
    checkCount++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    else
      passCount++;
  endtask

  task automatic applyStimulus(input logic done, input logic [15:0] data, input logic ack,
                               input logic [15:0] pcu, input logic hlt);
    imem_done  = done;
    imem_data  = data;
    instr_ack  = ack;
    pc_updated = pcu;
    halt       = hlt;
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    expPc = 16'h0000;
    scoreboard.delete();
  endtask

  // One full fetch: wait for the request, answer after 'delay' idle cycles,
  // check the presented instruction, then acknowledge with next_pc.
  task automatic fetchOne(input logic [15:0] data, input int delay, input logic [15:0] nextPc, input int mode);
    int          n;
    logic [31:0] exp;
    logic [15:0] nextExp;
    n = 0;
    while (imem_rd !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checkOutput("rd_wait", imem_rd, 16'd1);
    checkOutput("addr", imem_addr, expPc);
    for (int i = 0; i < delay; i++) begin
      applyStimulus(1'b0, 16'hBAD0, 1'b0, 16'h0000, 1'b0);
      checkOutput("addr_stable", imem_addr, expPc);
      checkOutput("valid_wait", instr_valid, 16'd0);
      checkOutput("err_wait", err, 16'd0);
      tick();
    end
    applyStimulus(1'b1, data, 1'b0, 16'h0000, 1'b0);
    nextExp = expPc + 16'd2;
    scoreboard.push_back({data, nextExp});
    tick();
    applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
    checkOutput("valid", instr_valid, 16'd1);
    checkOutput("rd_in_valid", imem_rd, 16'd0);
    checkOutput("sb_size", 16'(scoreboard.size()), 16'd1);
    if (scoreboard.size() > 0) begin
      exp = scoreboard.pop_front();
      checkOutput("instr", instr, exp[31:16]);
      checkOutput("pc_plus_2", pc_plus_2, exp[15:0]);
      tick();
      checkOutput("valid_hold", instr_valid, 16'd1);
      checkOutput("instr_hold", instr, exp[31:16]);
    end
    applyStimulus(1'b0, 16'h0000, 1'b1, nextPc, mode == MODE_HALT);
    tick();
    applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
    if (mode == MODE_NEXT) begin
      expPc = nextPc;
      checkOutput("redir_rd", imem_rd, 16'd1);
      checkOutput("redir_addr", imem_addr, nextPc);
      checkOutput("redir_valid", instr_valid, 16'd0);
    end else if (mode == MODE_HALT) begin
      expPc = nextPc;
      checkOutput("halt_halted", halted, 16'd1);
      checkOutput("halt_rd", imem_rd, 16'd0);
      checkOutput("halt_err", err, 16'd0);
    end else begin
      checkOutput("mis_err", err, 16'd1);
      checkOutput("mis_halted", halted, 16'd1);
      checkOutput("mis_rd", imem_rd, 16'd0);
      checkOutput("mis_pc_kept", imem_addr, expPc);
    end
  endtask

  // Directed sequence covering normal fetch, wait states, timeout, halt,
  // misaligned redirect, PC wrap and reset during an outstanding request.
  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
    expPc = 16'h0000;
    tick();
    tick();
    checkOutput("rst_rd", imem_rd, 16'd0);
    checkOutput("rst_valid", instr_valid, 16'd0);
    checkOutput("rst_halted", halted, 16'd0);
    checkOutput("rst_err", err, 16'd0);
    checkOutput("rst_instr", instr, 16'h0800);
    checkOutput("rst_addr", imem_addr, 16'h0000);
    checkOutput("rst_pc2", pc_plus_2, 16'h0002);
    rst = 1'b0;
    checkOutput("idle_rd", imem_rd, 16'd0);
    tick();
    checkOutput("first_rd", imem_rd, 16'd1);

    fetchOne(16'h4001, 0, 16'h0010, MODE_NEXT);
    fetchOne(16'h1234, 3, 16'hFFFE, MODE_NEXT);
    fetchOne(16'h5678, 0, 16'h0020, MODE_NEXT);
    fetchOne(16'h9ABC, 7, 16'h0030, MODE_NEXT);
    checkOutput("err_done_last", err, 16'd0);

    for (int i = 0; i < 7; i++) begin
      checkOutput("to_rd", imem_rd, 16'd1);
      checkOutput("to_err", err, 16'd0);
      tick();
    end
    checkOutput("to_rd_last", imem_rd, 16'd1);
    tick();
    checkOutput("to_err_set", err, 16'd1);
    checkOutput("to_halted", halted, 16'd1);
    checkOutput("to_rd_off", imem_rd, 16'd0);
    applyStimulus(1'b1, 16'h7777, 1'b1, 16'h0100, 1'b0);
    tick();
    tick();
    applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
    checkOutput("to_stay_halted", halted, 16'd1);
    checkOutput("to_stay_valid", instr_valid, 16'd0);
    checkOutput("to_stay_addr", imem_addr, 16'h0030);

    doReset();
    checkOutput("clr_err", err, 16'd0);
    checkOutput("clr_halted", halted, 16'd0);
    checkOutput("clr_addr", imem_addr, 16'h0000);
    checkOutput("clr_instr", instr, 16'h0800);
    tick();
    fetchOne(16'hF000, 0, 16'h0040, MODE_HALT);
    for (int i = 0; i < 20; i++) begin
      tick();
      checkOutput("hlt_rd", imem_rd, 16'd0);
    end
    checkOutput("hlt_halted", halted, 16'd1);
    checkOutput("hlt_addr", imem_addr, 16'h0040);

    doReset();
    tick();
    fetchOne(16'hAAAA, 0, 16'h0013, MODE_MISALIGN);

    doReset();
    tick();
    fetchOne(16'h1111, 0, 16'h0050, MODE_NEXT);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    applyStimulus(1'b1, 16'hDEAD, 1'b0, 16'h0000, 1'b0);
    tick();
    applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
    expPc = 16'h0000;
    scoreboard.delete();
    checkOutput("late_rd", imem_rd, 16'd1);
    checkOutput("late_addr", imem_addr, 16'h0000);
    checkOutput("late_instr", instr, 16'h0800);
    checkOutput("late_valid", instr_valid, 16'd0);
    fetchOne(16'h2222, 1, 16'h0002, MODE_NEXT);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
